// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and control-field bubbling
module pipe_stage_reg #(
  parameter int DATA_W = 71,
  parameter int CTRL_W = 3,
  parameter bit SKID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] main_q, skid_q, ctrl_mask;
  logic in_fire, out_fire, load_in, load_skid, load_from_skid;
  always_comb begin
    for (int i = 0; i < DATA_W; i++) ctrl_mask[i] = (i >= DATA_W - CTRL_W);
  end
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // in FULL in_ready is low, so any in_fire here targets main or skid from EMPTY/ONE
  assign load_in = in_fire && (state == EMPTY || out_fire);
  assign load_skid = SKID && in_fire && state == ONE && !out_fire;
  assign load_from_skid = state == FULL && out_fire;
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = flush ? EMPTY :
               load_skid ? FULL :
               load_from_skid ? ONE :
               in_fire ? ONE :
               out_fire ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= flush ? main_q & ~ctrl_mask :
                load_from_skid ? skid_q :
                load_in ? in_data : main_q;
      skid_q <= (load_skid && !flush) ? in_data : skid_q;
    end
  end
  always_comb begin
    out_valid = state != EMPTY;
    count = state;
    in_ready = SKID ? state != FULL : (!out_valid || out_ready);
    out_data = out_valid ? main_q : main_q & ~ctrl_mask;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus an ordered stream check for both skid modes
module tb_pipe_stage_reg;
  logic clk = 0, rst, flush, iv, ordy;
  logic [70:0] id;
  logic ir1, ov1, ir0, ov0;
  logic [70:0] od1, od0;
  logic [1:0] cnt1, cnt0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(71), .CTRL_W(3), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir1), .in_data(id),
    .out_valid(ov1), .out_ready(ordy), .out_data(od1), .count(cnt1));
  pipe_stage_reg #(.DATA_W(71), .CTRL_W(3), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir0), .in_data(id),
    .out_valid(ov0), .out_ready(ordy), .out_data(od0), .count(cnt0));

  typedef struct {
    logic sel, chk, rst, flush, iv;
    logic [70:0] id;
    logic ordy, ev;
    logic [70:0] ed;
    logic [1:0] ec;
    logic eir;
  } vec_t;
  vec_t q[$];

  function automatic logic [70:0] pl(input logic [2:0] c, input logic [67:0] d);
    return {c, d};
  endfunction

  task automatic add(input logic sel, chk, r, f, v, input logic [70:0] d, input logic o,
                     input logic ev, input logic [70:0] ed, input logic [1:0] ec, input logic eir);
    q.push_back('{sel, chk, r, f, v, d, o, ev, ed, ec, eir});
  endtask

  task automatic check(input string nm, input int k, input logic [70:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  logic [70:0] exp_s[20];
  int sent, recv;

  initial begin
    rst = 1; flush = 0; iv = 0; ordy = 0; id = '0;
    // reset with in_valid high and all-ones payload
    add(1, 0, 1, 0, 1, {71{1'b1}}, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // streaming
    add(1, 1, 0, 0, 1, pl(1, 'h10), 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, pl(2, 'h11), 1, 1, pl(1, 'h10), 1, 1);
    add(1, 1, 0, 0, 1, pl(3, 'h12), 1, 1, pl(2, 'h11), 1, 1);
    add(1, 1, 0, 0, 0, 0, 1, 1, pl(3, 'h12), 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, pl(0, 'h12), 0, 1);
    // back-pressure
    add(1, 1, 0, 0, 1, pl(5, 'hA0), 0, 0, pl(0, 'h12), 0, 1);
    add(1, 1, 0, 0, 1, pl(6, 'hA1), 0, 1, pl(5, 'hA0), 1, 1);
    add(1, 1, 0, 0, 1, pl(7, 'hA2), 0, 1, pl(5, 'hA0), 2, 0);
    add(1, 1, 0, 0, 1, pl(7, 'hA2), 1, 1, pl(5, 'hA0), 2, 0);
    add(1, 1, 0, 0, 1, pl(7, 'hA2), 1, 1, pl(6, 'hA1), 1, 1);
    add(1, 1, 0, 0, 0, 0, 1, 1, pl(7, 'hA2), 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, pl(0, 'hA2), 0, 1);
    // flush while FULL
    add(1, 1, 0, 0, 1, pl(7, 'hB0), 0, 0, pl(0, 'hA2), 0, 1);
    add(1, 1, 0, 0, 1, pl(7, 'hB1), 0, 1, pl(7, 'hB0), 1, 1);
    add(1, 1, 0, 1, 1, pl(7, 'hB2), 0, 1, pl(7, 'hB0), 2, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, pl(0, 'hB0), 0, 1);
    // flush in ONE with in_fire and out_fire: offered payload discarded
    add(1, 1, 0, 0, 1, pl(4, 'hC0), 0, 0, pl(0, 'hB0), 0, 1);
    add(1, 1, 0, 1, 1, pl(4, 'hC1), 1, 1, pl(4, 'hC0), 1, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0, pl(0, 'hC0), 0, 1);
    // rst and flush together while FULL
    add(1, 1, 0, 0, 1, pl(7, 'hD0), 0, 0, pl(0, 'hC0), 0, 1);
    add(1, 1, 0, 0, 1, pl(7, 'hD1), 0, 1, pl(7, 'hD0), 1, 1);
    add(1, 1, 1, 1, 1, pl(7, 'hD2), 0, 1, pl(7, 'hD0), 2, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    // single-entry mode: combinational ready
    add(0, 1, 0, 0, 1, pl(1, 'hE0), 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, pl(2, 'hE1), 0, 1, pl(1, 'hE0), 1, 0);
    add(0, 1, 0, 0, 1, pl(2, 'hE1), 1, 1, pl(1, 'hE0), 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, pl(2, 'hE1), 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1, pl(2, 'hE1), 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, pl(0, 'hE1), 0, 1);

    for (int k = 0; k < q.size(); k++) begin
      rst = q[k].rst; flush = q[k].flush; iv = q[k].iv; id = q[k].id; ordy = q[k].ordy;
      #2;
      if (q[k].chk) begin
        check("out_valid", k, q[k].sel ? ov1 : ov0, q[k].ev);
        check("out_data", k, q[k].sel ? od1 : od0, q[k].ed);
        check("count", k, q[k].sel ? cnt1 : cnt0, q[k].ec);
        check("in_ready", k, q[k].sel ? ir1 : ir0, q[k].eir);
      end
      @(posedge clk); #1;
    end

    // ordered stream through the skid stage under intermittent back-pressure
    rst = 1; iv = 0; flush = 0; ordy = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 20; i++) exp_s[i] = pl(3'(i % 8), 68'('h100 + i));
    sent = 0; recv = 0;
    for (int c = 0; c < 300 && recv < 20; c++) begin
      iv = sent < 20;
      id = sent < 20 ? exp_s[sent] : '0;
      ordy = !(c % 5 == 1 || c % 5 == 2);
      #2;
      if (ov1 && ordy) begin
        check("stream_data", recv, od1, exp_s[recv]);
        recv++;
      end
      if (iv && ir1) sent++;
      check("stream_count_le2", c, cnt1 <= 2'd2, 1);
      @(posedge clk); #1;
    end
    check("stream_done", 0, recv, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and control-field bubbling. It replaces the fixed per-stage registers between ID/EXE/MEM/WB: each stage boundary instantiates one copy, with the stage's enable bits (wb_en, mem_r_en, mem_w_en, ...) packed into the control field. Back-pressure from a stalled downstream stage is absorbed without losing the in-flight instruction, and a flush inserts a bubble whose enables are guaranteed zero.

## Interface
- DATA_W, 71: total payload width in bits (control field plus data field).
- CTRL_W, 3: width of the control field, occupying payload bits [DATA_W-1 : DATA_W-CTRL_W]; 1 <= CTRL_W <= DATA_W.
- SKID, 1: 1 = two-entry skid mode with registered in_ready; 0 = single-entry mode with pass-through ready.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DATA_W  head payload.
- count  out  2  number of entries held (0..2).

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and, when SKID=1, a skid register.
- States (SKID=1): EMPTY (count 0), ONE (main valid), FULL (main + skid valid).
  - EMPTY: in_fire -> ONE, main <= in_data; otherwise stay in EMPTY.
  - ONE with in_fire & out_fire: stay in ONE, main <= in_data.
  - ONE with in_fire only: -> FULL, skid <= in_data.
  - ONE with out_fire only: -> EMPTY.
  - ONE with neither: stay in ONE, main holds.
  - FULL: in_ready = 0. out_fire -> ONE, main <= skid. Otherwise stay in FULL.
- in_ready (SKID=1) = (state != FULL). It is a function of registered state only, with no combinational path from out_ready.
- SKID=0: only EMPTY and ONE exist.
  - in_ready = ~out_valid | out_ready, a combinational path from out_ready.
  - in_fire loads main. out_fire without in_fire -> EMPTY.
  - count never exceeds 1.
- Bubbling:
  - Whenever out_valid = 0, out_data control field = 0.
  - When out_valid = 0, the data field holds its last value (zero after reset).
  - The skid control field is don't-care when the skid register is not valid.
- Flush (priority below rst, above everything else):
  - Next state is EMPTY; count = 0; main control field cleared.
  - Any in_fire in the flush cycle is discarded. Upstream treats it as consumed.
  - Any out_fire in the flush cycle completes normally; downstream saw valid data in that cycle.
- Payload bits pass through bit-exact; no arithmetic is performed on them.

## Timing
- Reset: on a rising edge with rst = 1, all state is cleared. After that edge:
  - state = EMPTY, out_valid = 0, count = 0.
  - out_data = 0 (all DATA_W bits), skid register = 0.
  - in_ready = 1.
- in_valid presented while rst = 1 is ignored.
- Reset mid-operation drops all held entries with no drain.
- Latency: in_fire at edge N gives out_valid = 1 and out_data = payload after edge N.
- Throughput: 1 payload per cycle while out_ready = 1.
- Stall (SKID=1), when out_ready drops with main valid and in_valid = 1:
  - exactly one further payload is accepted into skid;
  - in_ready falls after that edge.
- Release from FULL:
  - the first out_fire moves skid into main;
  - in_ready returns to 1 the cycle after.
- Order is strictly FIFO; no payload is duplicated or lost except by flush or rst.
- rst and flush together: rst wins; the outcome is identical to rst alone.

## Test plan
- Reset: drive in_valid = 1, in_data = all-ones during rst -> after release, out_valid = 0, out_data = 0, count = 0, in_ready = 1.
- Streaming, SKID=1, out_ready = 1: inputs 0x10, 0x11, 0x12 on consecutive cycles -> same values on out_data one cycle later each, count = 1 throughout.
- Back-pressure: hold out_ready = 0 while feeding 0xA0, 0xA1, 0xA2 -> 0xA0 and 0xA1 accepted, count = 2, in_ready = 0, 0xA2 held upstream. Then out_ready = 1 -> output order 0xA0, 0xA1, 0xA2 with no gap after the first release cycle.
- Flush in FULL: with count = 2 and control bits = 3'b111, assert flush for 1 cycle -> next cycle out_valid = 0, control field = 0, count = 0, in_ready = 1. A payload offered in the flush cycle never appears.
- SKID=0: out_ready = 0 with main valid -> in_ready = 0 in the same cycle. Raise out_ready -> in_ready = 1 combinationally; the new payload replaces main at the next edge; count stays at most 1.
- rst and flush asserted together while in FULL -> full reset values; the skid contents never emerge.
